avalon_burst_read_slave: RTL

//  Avalon-MM burst-read slave memory; the downstream stage of the burst read master's

---
 rtl/avalon_burst_read_slave.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/avalon_burst_read_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | avalon_burst_read_slave: Avalon-MM burst-read slave memory with command  |
// | FIFO and fixed latency. Optional macro AVS_STALL_EN: 1 stall after every |
// | 4th beat. Revision: 1.0                                                  |
// +--------------------------------------------------------------------------+
module avalon_burst_read_slave #(
  parameter int DATAWIDTH       = 32,
  parameter int BYTEENABLEWIDTH = 4,
  parameter int ADDRESSWIDTH    = 32,
  parameter int BURSTCOUNTWIDTH = 5,
  parameter int MAXBURSTCOUNT   = 16,
  parameter int MEM_DEPTH_LOG2  = 10,
  parameter int CMD_DEPTH       = 4,
  parameter int READ_LATENCY    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDRESSWIDTH-1:0]    slave_address,
  input  logic                       slave_read,
  input  logic [BURSTCOUNTWIDTH-1:0] slave_burstcount,
  input  logic [BYTEENABLEWIDTH-1:0] slave_byteenable,
  output logic                       slave_waitrequest,
  output logic                       slave_readdatavalid,
  output logic [DATAWIDTH-1:0]       slave_readdata,
  input  logic                       init_write,
  input  logic [MEM_DEPTH_LOG2-1:0]  init_address,
  input  logic [DATAWIDTH-1:0]       init_writedata,
  output logic                       busy,
  output logic                       err_burstcount
);

  localparam int c_addr_shift = $clog2(BYTEENABLEWIDTH);
  localparam int c_ptr_w      = $clog2(CMD_DEPTH);
  localparam int c_cnt_w      = c_ptr_w + 1;
  localparam int c_entry_w    = MEM_DEPTH_LOG2 + BURSTCOUNTWIDTH;
  localparam int c_lat_w      = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [c_cnt_w-1:0]         c_fifo_full = c_cnt_w'(CMD_DEPTH);
  localparam logic [BURSTCOUNTWIDTH-1:0] c_max_burst = BURSTCOUNTWIDTH'(MAXBURSTCOUNT);
  localparam logic [BURSTCOUNTWIDTH-1:0] c_one_beat  = BURSTCOUNTWIDTH'(1);
  localparam logic [c_lat_w-1:0]         c_lat_init  = c_lat_w'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [c_cnt_w-1:0]         count_q, count_d;
  logic [c_ptr_w-1:0]         wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0]         rd_ptr_q, rd_ptr_d;
  logic [MEM_DEPTH_LOG2-1:0]  addr_q, addr_d;
  logic [BURSTCOUNTWIDTH-1:0] remaining_q, remaining_d;
  logic [c_lat_w-1:0]         lat_q, lat_d;
  logic                       valid_q, valid_d;
  logic [DATAWIDTH-1:0]       rdata_q, rdata_d;
  logic                       err_q, err_d;
`ifdef AVS_STALL_EN
  logic [1:0]                 beat_q, beat_d;
  logic                       stall_q, stall_d;
`endif

  logic [c_entry_w-1:0] cmd_mem [CMD_DEPTH];
  logic [DATAWIDTH-1:0] mem [2**MEM_DEPTH_LOG2];

  logic                       w_full, w_push, w_pop, w_legal, w_beat_en;
  logic [MEM_DEPTH_LOG2-1:0]  w_word_addr;
  logic [BURSTCOUNTWIDTH-1:0] w_beats;
  logic [c_entry_w-1:0]       w_pop_entry;
  logic                       w_unused_ok;

  assign w_full            = (count_q == c_fifo_full);
  assign slave_waitrequest = reset | w_full;
  // Reset is kept out of the flop data paths; every state flop is held by the async reset anyway.
  assign w_push      = slave_read & ~w_full;
  assign w_pop       = (state_q == ST_IDLE) && (count_q != '0);
  assign w_word_addr = slave_address[c_addr_shift +: MEM_DEPTH_LOG2];
  assign w_legal     = (slave_burstcount != '0) && (slave_burstcount <= c_max_burst);
  assign w_beats     = w_legal ? slave_burstcount : c_one_beat;
  assign w_pop_entry = cmd_mem[rd_ptr_q];
  assign w_unused_ok = ^{slave_byteenable, slave_address};

`ifdef AVS_STALL_EN
  assign w_beat_en = (state_q == ST_BURST) & ~stall_q;
`else
  assign w_beat_en = (state_q == ST_BURST);
`endif

  assign busy                = (count_q != '0) | (state_q != ST_IDLE);
  assign slave_readdatavalid = valid_q;
  assign slave_readdata      = rdata_q;
  assign err_burstcount      = err_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    lat_d       = lat_q;
    valid_d     = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q | (w_push & ~w_legal);
`ifdef AVS_STALL_EN
    beat_d      = beat_q;
    stall_d     = stall_q;
`endif

    if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    unique case (state_q)
      ST_IDLE: begin
        if (w_pop) begin
          addr_d      = w_pop_entry[c_entry_w-1 -: MEM_DEPTH_LOG2];
          remaining_d = w_pop_entry[BURSTCOUNTWIDTH-1:0];
          lat_d       = c_lat_init;
          state_d     = ST_WAIT;
`ifdef AVS_STALL_EN
          beat_d      = 2'd0;
          stall_d     = 1'b0;
`endif
        end
      end
      ST_WAIT: begin
        if (lat_q == '0) state_d = ST_BURST;
        else             lat_d   = lat_q - 1'b1;
      end
      ST_BURST: begin
        if (w_beat_en) begin
          valid_d     = 1'b1;
          rdata_d     = mem[addr_q];
          addr_d      = addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == c_one_beat) state_d = ST_IDLE;
`ifdef AVS_STALL_EN
          else if (beat_q == 2'd3)       stall_d = 1'b1;
          beat_d = beat_q + 1'b1;
`endif
        end
`ifdef AVS_STALL_EN
        else stall_d = 1'b0;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      addr_q      <= '0;
      remaining_q <= '0;
      lat_q       <= '0;
      valid_q     <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
`ifdef AVS_STALL_EN
      beat_q      <= 2'd0;
      stall_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      lat_q       <= lat_d;
      valid_q     <= valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
`ifdef AVS_STALL_EN
      beat_q      <= beat_d;
      stall_q     <= stall_d;
`endif
    end
  end

  // Storage arrays carry no reset: memory survives reset, stale FIFO slots are never read.
  always_ff @(posedge clk) begin
    if (w_push) cmd_mem[wr_ptr_q] <= {w_word_addr, w_beats};
    if (init_write) mem[init_address] <= init_writedata;
  end

endmodule
`default_nettype wire
